// File: rtl/part_arb3_ctrl.sv
// Three-channel FIFO-buffered round-robin merger onto one registered valid/ready stream.
// Optional macro PART_ARB3_SRC_TAG_EN adds o_src, the granted channel index loaded with o_data.
module part_arb3_ctrl #(
    parameter int DW    = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          wen0,
    input  logic          wen1,
    input  logic          wen2,
    input  logic [DW-1:0] i_data0,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [2:0]    o_full,
    output logic [2:0]    o_ovf,
`ifdef PART_ARB3_SRC_TAG_EN
    output logic [1:0]    o_src,
`endif
    output logic          o_busy
);
    // Handshake: a word transfers on a rising edge where o_valid && i_ready; o_valid/o_data
    // stay stable while o_valid && !i_ready, and o_valid never depends combinationally on i_ready.
    localparam logic [0:0]  ST_EMPTY = 1'b0;
    localparam logic [0:0]  ST_VALID = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] wdata [3];
    logic [DW-1:0] mem_q [3][DEPTH];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW:0]   cnt_q [3];
    logic [AW:0]   cnt_d [3];
    logic [2:0]    full_q, ovf_q;
    logic [2:0]    wen_v, push, pop, nonempty;
    logic [1:0]    cand [3];
    logic [1:0]    last_q, last_d, grant;
    logic [0:0]    state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;
    logic          load, found;

    assign wdata[0] = i_data0;
    assign wdata[1] = i_data1;
    assign wdata[2] = i_data2;

    always_comb begin
        wen_v = {wen2, wen1, wen0};
        load  = (state_q == ST_EMPTY) || i_ready;
        for (int n = 0; n < 3; n++) begin
            nonempty[n] = (cnt_q[n] != '0);
            push[n]     = wen_v[n] && !full_q[n];
        end
        // Search order after the last grant: last+1, last+2, last (mod 3).
        cand[0] = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        cand[1] = (last_q == 2'd0) ? 2'd2 : last_q - 2'd1;
        cand[2] = last_q;
        found = 1'b0;
        grant = last_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && nonempty[cand[k]]) begin
                found = 1'b1;
                grant = cand[k];
            end
        end
        pop = '0;
        if (load && found) pop[grant] = 1'b1;
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            if (found) begin
                state_d = ST_VALID;
                data_d  = mem_q[grant][rd_ptr_q[grant]];
                last_d  = grant;
            end else begin
                state_d = ST_EMPTY;
            end
        end
        busy_d = (state_d == ST_VALID);
        for (int n = 0; n < 3; n++) begin
            cnt_d[n] = cnt_q[n] + {{AW{1'b0}}, push[n]} - {{AW{1'b0}}, pop[n]};
            if (cnt_d[n] != '0) busy_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < 3; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            full_q  <= '0;
            ovf_q   <= '0;
            state_q <= ST_EMPTY;
            data_q  <= '0;
            last_q  <= 2'd2;
            busy_q  <= 1'b0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (push[n]) wr_ptr_q[n] <= wr_ptr_q[n] + 1'b1;
                if (pop[n])  rd_ptr_q[n] <= rd_ptr_q[n] + 1'b1;
                cnt_q[n]  <= cnt_d[n];
                full_q[n] <= (cnt_d[n] == FULL_CNT);
            end
            ovf_q   <= ovf_q | (wen_v & full_q);
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 3; n++) begin
            if (push[n] && !i_rst) mem_q[n][wr_ptr_q[n]] <= wdata[n];
        end
    end

`ifdef PART_ARB3_SRC_TAG_EN
    logic [1:0] src_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_q <= '0;
        end else if (load && found) begin
            src_q <= grant;
        end
    end
    assign o_src = src_q;
`endif

    assign o_valid = (state_q == ST_VALID);
    assign o_data  = data_q;
    assign o_full  = full_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_part_arb3_ctrl.sv
// Bench for part_arb3_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_part_arb3_ctrl;
    localparam int DW    = 9;
    localparam int DEPTH = 4;

    logic          i_clk, i_rst, wen0, wen1, wen2, i_ready;
    logic [DW-1:0] i_data0, i_data1, i_data2;
    logic          o_valid, o_busy;
    logic [DW-1:0] o_data;
    logic [2:0]    o_full, o_ovf;
`ifdef PART_ARB3_SRC_TAG_EN
    logic [1:0]    o_src;
`endif

    part_arb3_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .wen0(wen0), .wen1(wen1), .wen2(wen2),
        .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
        .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
        .o_full(o_full), .o_ovf(o_ovf),
`ifdef PART_ARB3_SRC_TAG_EN
        .o_src(o_src),
`endif
        .o_busy(o_busy)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mq [3][$];
    logic [DW-1:0] exp_q [$];
    logic          m_valid, m_busy, m_init;
    logic [DW-1:0] m_data;
    logic [2:0]    m_full, m_ovf;
    int            m_last, m_src;
    initial m_init = 1'b0;

    always @(posedge i_clk) begin : model
        int sz [3];
        int g;
        logic [2:0]    w;
        logic [DW-1:0] d [3];
        w = {wen2, wen1, wen0};
        d[0] = i_data0; d[1] = i_data1; d[2] = i_data2;
        if (i_rst) begin
            for (int n = 0; n < 3; n++) mq[n].delete();
            exp_q.delete();
            m_valid = 1'b0; m_data = '0; m_ovf = '0; m_last = 2; m_src = 0;
            m_init = 1'b1;
        end else begin
            for (int n = 0; n < 3; n++) sz[n] = mq[n].size();
            if (!m_valid || i_ready) begin
                g = -1;
                for (int k = 1; k <= 3; k++)
                    if (g < 0 && sz[(m_last + k) % 3] > 0) g = (m_last + k) % 3;
                if (g >= 0) begin
                    m_data = mq[g].pop_front();
                    m_valid = 1'b1; m_last = g; m_src = g;
                    exp_q.push_back(m_data);
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (w[n]) begin
                    if (sz[n] == DEPTH) m_ovf[n] = 1'b1;
                    else mq[n].push_back(d[n]);
                end
            end
        end
        m_busy = m_valid;
        for (int n = 0; n < 3; n++) begin
            m_full[n] = (mq[n].size() == DEPTH);
            if (mq[n].size() != 0) m_busy = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        logic [DW-1:0] e;
        if (m_init) begin
            check("o_valid", 32'(o_valid), 32'(m_valid));
            check("o_data", 32'(o_data), 32'(m_data));
            check("o_full", 32'(o_full), 32'(m_full));
            check("o_ovf", 32'(o_ovf), 32'(m_ovf));
            check("o_busy", 32'(o_busy), 32'(m_busy));
`ifdef PART_ARB3_SRC_TAG_EN
            check("o_src", 32'(o_src), 32'(m_src));
`endif
            if (o_valid === 1'b1 && i_ready === 1'b1 && i_rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(o_data), 32'h7fff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", 32'(o_data), 32'(e));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [2:0] w, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic rdy, input logic rst);
        wen0 = w[0]; wen1 = w[1]; wen2 = w[2];
        i_data0 = d0; i_data1 = d1; i_data2 = d2;
        i_ready = rdy; i_rst = rst;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) drive(3'b000, '0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        drive(3'b000, '0, '0, '0, 1'b1, 1'b1);
        drive(3'b000, '0, '0, '0, 1'b1, 1'b1);
        // single write on channel 1
        drive(3'b010, '0, 9'h0A5, '0, 1'b1, 1'b0);
        idle(4, 1'b1);
        // round robin over two preloaded words per channel
        drive(3'b111, 9'h001, 9'h011, 9'h021, 1'b0, 1'b0);
        drive(3'b111, 9'h002, 9'h012, 9'h022, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);
        // backpressure on a held word
        drive(3'b001, 9'h1FF, '0, '0, 1'b0, 1'b0);
        drive(3'b010, '0, 9'h055, '0, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b1);
        // overflow on channel 2 behind a held output word
        drive(3'b001, 9'h0C0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(3'b100, '0, '0, 9'(9'h130 + i), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);
        // simultaneous push/pop on channel 0
        drive(3'b001, 9'h041, '0, '0, 1'b0, 1'b0);
        drive(3'b001, 9'h042, '0, '0, 1'b0, 1'b0);
        drive(3'b001, 9'h043, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(3'b001, 9'(9'h050 + i), '0, '0, 1'b1, 1'b0);
        idle(6, 1'b1);
        // reset mid-operation with a same-cycle write
        drive(3'b111, 9'h061, 9'h071, 9'h081, 1'b0, 1'b0);
        drive(3'b111, 9'h062, 9'h072, 9'h082, 1'b0, 1'b0);
        drive(3'b001, 9'h0EE, '0, '0, 1'b0, 1'b1);
        drive(3'b010, '0, 9'h0B7, '0, 1'b1, 1'b0);
        idle(4, 1'b1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] w;
            for (int n = 0; n < 3; n++) w[n] = ($urandom_range(0, 9) < 6);
            drive(w, 9'($urandom), 9'($urandom), 9'($urandom),
                  (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 299) == 0));
        end
        idle(30, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
